// File: rtl/morty_pkg.sv
// Shared definitions for the morty pipeline: write-back source selects and trap-code width.
package morty_pkg;

  localparam int TRAP_CODE_W = 4;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_PC4  = 2'b01,
    WB_SEL_CSR  = 2'b10,
    WB_SEL_ZERO = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/morty_instret_counter.sv
// Retired-instruction counter; wraps silently from all-ones to zero.
module morty_instret_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (inc_i) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/morty_wb_stage.sv
// Write-back stage: MEM/WB pipeline register feeding the register file, CSR file,
// forwarding network, trap logic and the retired-instruction counter.
module morty_wb_stage
  import morty_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [XLEN-1:0]        PC_wb_i,
  input  logic [XLEN-1:0]        PC4_wb_i,
  input  logic [4:0]             rd_wb_i,
  input  logic [XLEN-1:0]        data_or_alu_wb_i,
  input  logic [XLEN-1:0]        csr_data_wb_i,
  input  logic [11:0]            csr_addr_wb_i,
  input  logic [TRAP_CODE_W-1:0] trap_code_wb_i,
  input  logic                   is_trap_wb_i,
  input  logic                   is_rs0_wb_i,
  input  logic                   rf_we_i,
  input  logic                   csr_we_i,
  input  logic [1:0]             wb_sel_i,
  input  logic [XLEN-1:0]        csr_rdata_i,
  output logic                   rf_we_o,
  output logic [4:0]             rf_waddr_o,
  output logic [XLEN-1:0]        rf_wdata_o,
  output logic                   fwd_valid_o,
  output logic [4:0]             fwd_rd_o,
  output logic [XLEN-1:0]        fwd_data_o,
  output logic                   csr_we_o,
  output logic [11:0]            csr_addr_o,
  output logic [XLEN-1:0]        csr_wdata_o,
  output logic                   trap_valid_o,
  output logic [TRAP_CODE_W-1:0] trap_code_o,
  output logic [XLEN-1:0]        trap_pc_o,
  output logic [CNT_W-1:0]       instret_o
);

  logic                   r_valid;
  logic [XLEN-1:0]        r_pc;
  logic [XLEN-1:0]        r_pc4;
  logic [4:0]             r_rd;
  logic [XLEN-1:0]        r_data;
  logic [XLEN-1:0]        r_csr_data;
  logic [11:0]            r_csr_addr;
  logic [TRAP_CODE_W-1:0] r_trap_code;
  logic                   r_is_trap;
  logic                   r_is_rs0;
  logic                   r_rf_we;
  logic                   r_csr_we;
  wb_sel_e                r_wb_sel;

  logic                   w_rf_we;
  logic [XLEN-1:0]        w_rf_wdata;
  logic                   w_retire;

  // Stall and flush both insert a bubble rather than holding, so an entry can never retire twice.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_pc4       <= '0;
      r_rd        <= '0;
      r_data      <= '0;
      r_csr_data  <= '0;
      r_csr_addr  <= '0;
      r_trap_code <= '0;
      r_is_trap   <= 1'b0;
      r_is_rs0    <= 1'b0;
      r_rf_we     <= 1'b0;
      r_csr_we    <= 1'b0;
      r_wb_sel    <= WB_SEL_ALU;
    end else begin
      r_valid     <= (flush_i || stall_i) ? 1'b0 : valid_i;
      r_pc        <= PC_wb_i;
      r_pc4       <= PC4_wb_i;
      r_rd        <= rd_wb_i;
      r_data      <= data_or_alu_wb_i;
      r_csr_data  <= csr_data_wb_i;
      r_csr_addr  <= csr_addr_wb_i;
      r_trap_code <= trap_code_wb_i;
      r_is_trap   <= is_trap_wb_i;
      r_is_rs0    <= is_rs0_wb_i;
      r_rf_we     <= rf_we_i;
      r_csr_we    <= csr_we_i;
      r_wb_sel    <= wb_sel_e'(wb_sel_i);
    end
  end

  always_comb begin
    w_rf_wdata = '0;
    case (r_wb_sel)
      WB_SEL_ALU: w_rf_wdata = r_data;
      WB_SEL_PC4: w_rf_wdata = r_pc4;
      WB_SEL_CSR: w_rf_wdata = csr_rdata_i;
      default:    w_rf_wdata = '0;
    endcase
  end

  assign w_rf_we  = r_valid && r_rf_we && !r_is_trap && (r_rd != 5'd0);
  assign w_retire = r_valid && !r_is_trap;

  assign rf_we_o     = w_rf_we;
  assign rf_waddr_o  = r_rd;
  assign rf_wdata_o  = w_rf_wdata;

  assign fwd_valid_o = w_rf_we;
  assign fwd_rd_o    = r_rd;
  assign fwd_data_o  = w_rf_wdata;

  // A CSR read-set/clear with rs1=x0 must not write, only read.
  assign csr_we_o    = r_valid && r_csr_we && !r_is_trap && !r_is_rs0;
  assign csr_addr_o  = r_csr_addr;
  assign csr_wdata_o = r_csr_data;

  assign trap_valid_o = r_valid && r_is_trap;
  assign trap_code_o  = r_trap_code;
  assign trap_pc_o    = r_pc;

  morty_instret_counter #(
    .CNT_W(CNT_W)
  ) u_instret (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (w_retire),
    .count_o(instret_o)
  );

endmodule

// File: doc/morty_wb_stage.md
MORTY_WB_STAGE -- requirements
Module: morty_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width.
REQ-002 SHALL have parameter CNT_W, 64, retired-instruction counter width.
REQ-003 SHALL have port clk_i input 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i input 1: reset, asynchronous and active-high.
REQ-005 SHALL have inputs from MEM stage:
- valid_i 1
- stall_i 1: MEM stall_mem_o
- flush_i 1
- PC_wb_i XLEN
- PC4_wb_i XLEN
- rd_wb_i 5
- data_or_alu_wb_i XLEN
- csr_data_wb_i XLEN
- csr_addr_wb_i 12
- trap_code_wb_i 4
- is_trap_wb_i 1
- is_rs0_wb_i 1
- rf_we_i 1
- csr_we_i 1
- wb_sel_i 2
REQ-006 SHALL have input csr_rdata_i XLEN: CSR file read data for csr_addr_o.
REQ-007 SHALL have register-file outputs rf_we_o 1, rf_waddr_o 5, rf_wdata_o XLEN.
REQ-008 SHALL have forwarding outputs fwd_valid_o 1, fwd_rd_o 5, fwd_data_o XLEN.
REQ-009 SHALL have CSR outputs csr_we_o 1, csr_addr_o 12, csr_wdata_o XLEN.
REQ-010 SHALL have trap outputs trap_valid_o 1, trap_code_o 4, trap_pc_o XLEN.
REQ-011 SHALL have output instret_o CNT_W: retired-instruction count.

Function
REQ-012 SHALL register all MEM inputs into a MEM/WB register on each rising clk_i; one-cycle latency to all outputs.
REQ-013 SHALL use load priority flush_i > stall_i > normal; flush_i or stall_i loads a bubble (valid_q=0), never holds the old entry, so no instruction retires twice.
REQ-014 SHALL load valid_q=valid_i on a normal load; other fields load unconditionally.
REQ-015 SHALL select rf_wdata_o by wb_sel_q: 00 data_or_alu_q, 01 PC4_q, 10 csr_rdata_i, 11 zero.
REQ-016 SHALL drive rf_we_o = valid_q & rf_we_q & ~is_trap_q & (rd_q!=0); rf_waddr_o = rd_q.
REQ-017 SHALL drive fwd_valid_o, fwd_rd_o, fwd_data_o identical to rf_we_o, rf_waddr_o, rf_wdata_o in the same cycle.
REQ-018 SHALL drive csr_we_o = valid_q & csr_we_q & ~is_trap_q & ~is_rs0_q, with csr_addr_o = csr_addr_q and csr_wdata_o = csr_data_q.
REQ-019 SHALL pulse trap_valid_o = valid_q & is_trap_q for exactly the one cycle the trapping entry occupies WB, with trap_code_o = trap_code_q and trap_pc_o = PC_q.
REQ-020 SHALL increment instret_o by 1 in the cycle after each entry with valid_q & ~is_trap_q; it SHALL wrap from all-ones to 0 without a flag.
REQ-021 SHALL suppress rf/CSR writes and the instret increment for bubbles and traps.

Reset
REQ-022 SHALL, on rst_i asserted (asynchronous, including mid-stream), immediately clear valid_q, all registered fields, and instret_o to 0.
REQ-023 SHALL therefore hold rf_we_o, csr_we_o, fwd_valid_o, and trap_valid_o at 0 during reset; all data outputs SHALL read 0, except rf_wdata_o, which follows wb_sel_q=00 (i.e. 0).
REQ-024 SHALL accept a new entry on the first rising edge after rst_i deasserts.

Structure
REQ-025 SHALL take WB_SEL_ALU/PC4/CSR constants and the trap-code width from shared package morty_pkg.
REQ-026 SHALL contain one sub-module, morty_instret_counter (CNT_W-bit, inc and async-reset inputs).

Verification
REQ-027 SHALL be covered by: ALU op, rd=5, data 0x1234, wb_sel=00 -> next cycle rf_we_o=1, waddr 5, wdata 0x1234, fwd matches, instret 0->1.
REQ-028 SHALL be covered by: rd=0 with rf_we_i=1 -> rf_we_o=0, instret still increments.
REQ-029 SHALL be covered by: JAL PC=0x100, PC4=0x104, wb_sel=01 -> wdata 0x104; then is_trap=1, code 4, PC 0x200 -> trap_valid_o one cycle, code 4, pc 0x200, no rf write, instret unchanged.
REQ-030 SHALL be covered by: stall_i held 3 cycles with valid_i=1 -> 3 bubbles, single retire after release; flush_i with stall_i -> bubble.
REQ-031 SHALL be covered by: CSRRS with is_rs0=1 -> csr_we_o=0 while rf writes csr_rdata_i; instret preset to all-ones plus one retire -> 0.
REQ-032 SHALL be covered by: rst_i asserted mid-cycle -> all outputs 0 before next edge.
